bcd_seg_scan: RTL
=================

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 SHALL provide parameter CLKS_PER_DIGIT, default 1000, giving the display-clock count per digit slot (legal range 2..65535).
REQ-002 SHALL provide clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide rst  input  1  synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 SHALL provide units  input  4  BCD units digit from the upstream BCD counter.
REQ-005 SHALL provide tens  input  4  BCD tens digit.
REQ-006 SHALL provide hundreds  input  4  BCD hundreds digit.
REQ-007 SHALL provide load  input  1  capture strobe; when high, the three digit inputs are copied into the shadow registers.
REQ-008 SHALL provide blank_lz  input  1  leading-zero blanking enable.
REQ-009 SHALL provide seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 SHALL provide an  output  3  digit enables {hundreds,tens,units}, active-low, one-hot-low, registered.
REQ-011 SHALL provide frame  output  1  one-cycle pulse at the start of each scan frame.
REQ-012 SHALL provide err  output  1  high while any shadow digit is greater than 9.

Function
REQ-013 SHALL update shadow digits on every edge where load=1; digits not loaded SHALL hold their value; display SHALL use only shadow values.
REQ-014 SHALL run the scan FSM U -> G0 -> T -> G1 -> H -> G2 -> U cyclically; U, T and H last CLKS_PER_DIGIT cycles each, and G0, G1 and G2 last exactly 1 cycle each.
REQ-015 SHALL give a frame length of exactly 3*(CLKS_PER_DIGIT+1) cycles.
REQ-016 SHALL use a slot counter of width clog2(CLKS_PER_DIGIT) that counts 0..CLKS_PER_DIGIT-1 in U, T and H, and clears on every state change.
REQ-017 SHALL register seg, an and frame so that values visible in cycle n reflect the FSM state and shadow contents of cycle n-1 (1-cycle latency).
REQ-018 SHALL drive an and seg as follows: U gives an=3'b110, T gives an=3'b101, H gives an=3'b011, and gap states give an=3'b111 with seg=7'b1111111 (anti-ghosting).
REQ-019 SHALL decode digits 0-9 as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 SHALL display a shadow digit greater than 9 as a dash (seg=0111111) and SHALL NOT blank it.
REQ-021 SHALL, when blank_lz=1, blank hundreds (seg=1111111, an still asserted) if its shadow value is 0.
REQ-022 SHALL, when blank_lz=1, blank tens if both the hundreds and tens shadow values are 0.
REQ-023 SHALL never blank units; when blank_lz=0 it SHALL not blank any digit.
REQ-024 SHALL assert frame for one cycle on the output cycle corresponding to the G2->U transition.
REQ-025 SHALL compute err combinationally from the shadow registers, so it follows load with a 1-cycle delay.
REQ-026 SHALL, on a load coinciding with the last cycle of a slot, show the new value from the first output cycle of the next digit slot.
REQ-027 SHALL sample blank_lz every cycle; a change takes effect on the next output register update.

Reset
REQ-028 SHALL, on a reset edge, clear the shadow digits to 0, set the FSM to U and the counter to 0, and on the same edge set seg=1111111, an=3'b111, frame=0 and err=0.
REQ-029 SHALL give rst priority over load and over scan progression.
REQ-030 SHALL, when reset is applied mid-scan, restart the scan at U on the next cycle with no gap state.

Verification (CLKS_PER_DIGIT=4)
REQ-031 SHALL cover reset: hold rst 2 cycles -> seg=1111111, an=111, err=0; first cycle after release an=110, seg=1000000.
REQ-032 SHALL cover a normal scan: load 1,2,3 (hundreds,tens,units) -> an 110/seg 0110000 for 4 cycles, blank 1 cycle, 101/0100100 for 4 cycles, blank, 011/1111001 for 4 cycles, blank; frame pulses every 15 cycles.
REQ-033 SHALL cover leading-zero blanking: load 0,0,7 with blank_lz=1 -> units slot seg=1111000, tens and hundreds slots seg=1111111; with blank_lz=0, tens and hundreds slots show 1000000.
REQ-034 SHALL cover an invalid digit: load tens=4'hA -> err=1 one cycle later; tens slot seg=0111111; loading valid digits clears err.
REQ-035 SHALL cover a mid-slot load: load 9,9,9 in cycle 2 of the U slot -> units seg changes to 0010000 one cycle later; the frame period is unchanged.
REQ-036 SHALL cover reset mid-scan: assert rst during the T slot -> outputs blank, shadow=0; after release the scan resumes at U with the counter at 0.

Source files
------------

// File: rtl/bcd_seg_scan.sv
//------------------------------------------------------------------------------
// bcd_seg_scan -- three-digit multiplexed 7-segment driver with gap slots,
//                 leading-zero blanking and invalid-digit flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_seg_scan #(
  parameter int CLKS_PER_DIGIT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       load,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame,
  output logic       err
);

  localparam int            CW       = $clog2(CLKS_PER_DIGIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_DIGIT - 1);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;

  typedef enum logic [2:0] {
    S_U  = 3'd0,
    S_G0 = 3'd1,
    S_T  = 3'd2,
    S_G1 = 3'd3,
    S_H  = 3'd4,
    S_G2 = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    u_sh, t_sh, h_sh;
  logic [6:0]    seg_d;
  logic [2:0]    an_d;
  logic          g2_q;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b0111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      u_sh <= 4'd0;
      t_sh <= 4'd0;
      h_sh <= 4'd0;
    end else if (load) begin
      u_sh <= units;
      t_sh <= tens;
      h_sh <= hundreds;
    end
  end

  assign err = (u_sh > 4'd9) | (t_sh > 4'd9) | (h_sh > 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_U;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      S_U, S_T, S_H: begin
        if (cnt == CNT_LAST) begin
          case (state)
            S_U:     state_nxt = S_G0;
            S_T:     state_nxt = S_G1;
            default: state_nxt = S_G2;
          endcase
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_G0:    state_nxt = S_T;
      S_G1:    state_nxt = S_H;
      default: state_nxt = S_U;
    endcase
  end

  // Tens is only a leading zero when hundreds is also zero.
  always_comb begin
    an_d  = 3'b111;
    seg_d = SEG_OFF;
    case (state)
      S_U: begin
        an_d  = 3'b110;
        seg_d = seg_of(u_sh);
      end
      S_T: begin
        an_d  = 3'b101;
        seg_d = (blank_lz && h_sh == 4'd0 && t_sh == 4'd0) ? SEG_OFF : seg_of(t_sh);
      end
      S_H: begin
        an_d  = 3'b011;
        seg_d = (blank_lz && h_sh == 4'd0) ? SEG_OFF : seg_of(h_sh);
      end
      default: begin
        an_d  = 3'b111;
        seg_d = SEG_OFF;
      end
    endcase
  end

  // frame is delayed one extra stage so it lines up with the first units output.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg   <= SEG_OFF;
      an    <= 3'b111;
      g2_q  <= 1'b0;
      frame <= 1'b0;
    end else begin
      seg   <= seg_d;
      an    <= an_d;
      g2_q  <= (state == S_G2);
      frame <= g2_q;
    end
  end

endmodule

`default_nettype wire
